pll_lock_supervisor: RTL



---
 rtl/pll_sup_pkg.sv | 27 ++
 rtl/sync_bit.sv | 22 ++
 rtl/pll_lock_supervisor.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/pll_sup_pkg.sv
// Shared types and constants for the PLL lock supervisor.
//   pll_sup_state_t : supervisor FSM states
//   PLL_SUP_CNT_W   : width of the retry and lock-loss counters
//   pll_sup_max3    : helper for sizing the shared cycle counter
package pll_sup_pkg;

    typedef enum logic [2:0] {
        PLL_RESET,
        WAIT_LOCK,
        STABILIZE,
        RUN,
        FAIL
    } pll_sup_state_t;

    localparam int unsigned PLL_SUP_CNT_W = 8;

    function automatic int unsigned pll_sup_max3(input int unsigned a,
                                                 input int unsigned b,
                                                 input int unsigned c);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return m;
    endfunction

endpackage

// File: rtl/sync_bit.sv
// Multi-flop synchronizer for a single asynchronous level.
//   clk : destination clock
//   d   : asynchronous input
//   q   : input re-timed to clk after STAGES edges
// The data path has no reset so the chain stays a pure flop ladder.
module sync_bit #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic d,
    output logic q
);

    (* ASYNC_REG = "TRUE" *) logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk) begin
        sync_q <= {sync_q[STAGES-2:0], d};
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/pll_lock_supervisor.sv
// Sequences PLL reset pulses, waits for lock with a timeout and bounded retries,
// qualifies lock stability, then releases the downstream system reset. Loss of
// lock while running is counted and recovered automatically.
//   clk           : reference clock
//   rst           : synchronous active-high reset
//   pll_locked    : asynchronous PLL lock indication
//   pll_rst       : PLL reset request
//   sys_rst       : downstream reset, low only while running
//   lock_lost     : one-cycle pulse when lock drops while running
//   lock_loss_cnt : saturating count of lock_lost pulses
//   retry_cnt     : retries used in the current acquisition
//   fail          : sticky, acquisition abandoned
module pll_lock_supervisor
    import pll_sup_pkg::*;
#(
    parameter int unsigned SYNC_STAGES    = 2,
    parameter int unsigned PLL_RST_CYCLES = 24,
    parameter int unsigned LOCK_TIMEOUT   = 24000,
    parameter int unsigned STABLE_CYCLES  = 2400,
    parameter int unsigned MAX_RETRIES    = 7
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     pll_locked,
    output logic                     pll_rst,
    output logic                     sys_rst,
    output logic                     lock_lost,
    output logic [PLL_SUP_CNT_W-1:0] lock_loss_cnt,
    output logic [PLL_SUP_CNT_W-1:0] retry_cnt,
    output logic                     fail
);

    localparam int unsigned CNT_MAX = pll_sup_max3(PLL_RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES);
    localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(PLL_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);

    localparam logic [PLL_SUP_CNT_W-1:0] RETRY_MAX = PLL_SUP_CNT_W'(MAX_RETRIES);
    localparam logic [PLL_SUP_CNT_W-1:0] LOSS_SAT  = '1;

    logic lk;

    pll_sup_state_t state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [PLL_SUP_CNT_W-1:0] retry_d, loss_d;
    logic lost_d;

    sync_bit #(
        .STAGES(SYNC_STAGES)
    ) u_sync_locked (
        .clk(clk),
        .d  (pll_locked),
        .q  (lk)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CNT_W'(1);
        retry_d = retry_cnt;
        loss_d  = lock_loss_cnt;
        lost_d  = 1'b0;

        unique case (state_q)
            PLL_RESET: begin
                if (cnt_q == RST_LAST) begin
                    state_d = WAIT_LOCK;
                    cnt_d   = '0;
                end
            end

            WAIT_LOCK: begin
                // Lock seen in the timeout cycle still wins.
                if (lk) begin
                    state_d = STABILIZE;
                    cnt_d   = '0;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    cnt_d = '0;
                    if (retry_cnt == RETRY_MAX) begin
                        state_d = FAIL;
                    end else begin
                        state_d = PLL_RESET;
                        retry_d = retry_cnt + PLL_SUP_CNT_W'(1);
                    end
                end
            end

            STABILIZE: begin
                if (!lk) begin
                    state_d = WAIT_LOCK;
                    cnt_d   = '0;
                end else if (cnt_q == STABLE_LAST) begin
                    state_d = RUN;
                    cnt_d   = '0;
                    retry_d = '0;
                end
            end

            RUN: begin
                cnt_d = '0;
                if (!lk) begin
                    state_d = PLL_RESET;
                    lost_d  = 1'b1;
                    if (lock_loss_cnt != LOSS_SAT) begin
                        loss_d = lock_loss_cnt + PLL_SUP_CNT_W'(1);
                    end
                end
            end

            FAIL: begin
                cnt_d = '0;
            end

            default: begin
                state_d = PLL_RESET;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= PLL_RESET;
            cnt_q         <= '0;
            pll_rst       <= 1'b1;
            sys_rst       <= 1'b1;
            lock_lost     <= 1'b0;
            lock_loss_cnt <= '0;
            retry_cnt     <= '0;
            fail          <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            // pll_rst trails the state by one cycle so each pulse spans a full
            // PLL_RST_CYCLES clocks after reset release or lock loss.
            pll_rst       <= (state_q == PLL_RESET);
            // sys_rst tracks the state being entered so it rises with lock_lost.
            sys_rst       <= (state_d != RUN);
            lock_lost     <= lost_d;
            lock_loss_cnt <= loss_d;
            retry_cnt     <= retry_d;
            fail          <= (state_d == FAIL);
        end
    end

endmodule
